sram_sdp_pipe: RTL

Parametrised simple-dual-port synchronous RAM. It is the successor to the single-port registered-output 64x8 RAM. It adds the following:
- Independent write and read ports.
- Per-byte write enables.
- Selectable read latency and read-during-write behaviour.
- A read-valid strobe.
- A sequential clear-on-reset engine.

It is the general on-chip storage primitive for buffers and lookup tables in the design.

---
 rtl/sram_pkg.sv | 39 +++
 rtl/sram_clear_seq.sv | 68 ++++++
 rtl/sram_sdp_pipe.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/sram_pkg.sv
// -----------------------------------------------------------------------------
// sram_pkg
// Shared definitions for the simple-dual-port RAM (sram_sdp_pipe):
//   - RDW_OLD / RDW_NEW : read-during-write mode selectors
//   - sram_state_t      : CLEAR / READY encoding of the clear sequencer
//   - byte_merge()      : merges a new word into an old word under byte enables
// -----------------------------------------------------------------------------
package sram_pkg;

    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

    // Widest word byte_merge() handles. Callers size-cast their operands
    // to this width and cast the result back to their own width.
    localparam int MERGE_MAX_W = 1024;
    localparam int MERGE_MAX_B = MERGE_MAX_W / 8;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } sram_state_t;

    // Enabled bytes come from new_word, disabled bytes keep old_word.
    function automatic logic [MERGE_MAX_W-1:0] byte_merge(
        input logic [MERGE_MAX_W-1:0] old_word,
        input logic [MERGE_MAX_W-1:0] new_word,
        input logic [MERGE_MAX_B-1:0] be
    );
        logic [MERGE_MAX_W-1:0] res;
        res = old_word;
        for (int b = 0; b < MERGE_MAX_B; b++) begin
            if (be[b]) begin
                res[8*b +: 8] = new_word[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sram_clear_seq.sv
// -----------------------------------------------------------------------------
// sram_clear_seq
// CLEAR/READY state machine with an address counter. After reset it walks
// every address once, requesting an all-zero write per cycle, then settles
// in READY. With CLEAR_ON_RESET=0 reset goes straight to READY.
// Ports:
//   clk       in   clock (rising edge)
//   rst       in   synchronous active-high reset; restarts the clear at 0
//   busy      out  1 while the clear is in progress
//   clr_we    out  clear write strobe
//   clr_addr  out  address being cleared
// -----------------------------------------------------------------------------
module sram_clear_seq
    import sram_pkg::*;
#(
    parameter int ADDR_W         = 6,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              rst,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    sram_state_t       r_state;
    sram_state_t       w_state_next;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] w_cnt_next;
    logic              w_clr_we;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_clr_we     = 1'b0;
        case (r_state)
            CLEAR: begin
                w_clr_we   = 1'b1;
                w_cnt_next = r_cnt + ADDR_W'(1);
                // Leave on the same edge that writes the last address.
                if (r_cnt == '1) begin
                    w_state_next = READY;
                end
            end
            READY: begin
                w_clr_we = 1'b0;
            end
            default: begin
                w_state_next = READY;
            end
        endcase
    end

    assign busy     = (r_state == CLEAR);
    assign clr_we   = w_clr_we;
    assign clr_addr = r_cnt;

endmodule

// File: rtl/sram_sdp_pipe.sv
// -----------------------------------------------------------------------------
// sram_sdp_pipe
// Simple-dual-port synchronous RAM with per-byte write enables, 1- or 2-cycle
// read latency, selectable read-during-write behaviour, a read-valid strobe
// and an optional zero-fill after reset.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   wr_en/addr/data/be  write port (be bit i enables wr_data[8i+7:8i])
//   rd_en/addr          read request
//   rd_data, rd_valid   registered read result, RD_LAT cycles after request
//   busy                clear in progress; requests are dropped
// -----------------------------------------------------------------------------
module sram_sdp_pipe
    import sram_pkg::*;
#(
    parameter int DATA_W         = 8,
    parameter int ADDR_W         = 6,
    parameter int RD_LAT         = 1,
    parameter int RDW_MODE       = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [DATA_W/8-1:0] wr_be,
    input  logic                rd_en,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_valid,
    output logic                busy
);

    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 2 ** ADDR_W;

    logic              w_busy;
    logic              w_clr_we;
    logic [ADDR_W-1:0] w_clr_addr;

    sram_clear_seq #(
        .ADDR_W         (ADDR_W),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clear_seq (
        .clk      (clk),
        .rst      (rst),
        .busy     (w_busy),
        .clr_we   (w_clr_we),
        .clr_addr (w_clr_addr)
    );

    assign busy = w_busy;

    // User requests are only honoured once the clear has finished.
    logic w_usr_we;
    logic w_usr_re;
    assign w_usr_we = wr_en & ~w_busy;
    assign w_usr_re = rd_en & ~w_busy;

    // Write-port mux: the clear engine owns the port while busy.
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_data;
    logic [NB-1:0]     w_mem_be;

    assign w_mem_we   = w_clr_we | w_usr_we;
    assign w_mem_addr = w_clr_we ? w_clr_addr : wr_addr;
    assign w_mem_data = w_clr_we ? '0 : wr_data;
    assign w_mem_be   = w_clr_we ? '1 : wr_be;

    // One byte-wide array per lane so byte enables map onto independent
    // write strobes.
    logic [DATA_W-1:0] w_rd_word;

    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
        logic [7:0] r_mem [DEPTH];

        always_ff @(posedge clk) begin
            if (w_mem_we && w_mem_be[gi]) begin
                r_mem[w_mem_addr] <= w_mem_data[8*gi +: 8];
            end
        end

        assign w_rd_word[8*gi +: 8] = r_mem[rd_addr];
    end

    // New-data bypass: a same-address write on this edge is folded into the
    // captured word. In old-data mode the array read naturally returns the
    // pre-write contents.
    logic              w_byp_hit;
    logic [DATA_W-1:0] w_merged;
    logic [DATA_W-1:0] w_rd_next;

    assign w_byp_hit = (RDW_MODE == RDW_NEW) && w_usr_we && (wr_addr == rd_addr);
    assign w_merged  = DATA_W'(byte_merge(MERGE_MAX_W'(w_rd_word),
                                          MERGE_MAX_W'(wr_data),
                                          MERGE_MAX_B'(wr_be)));
    assign w_rd_next = w_byp_hit ? w_merged : w_rd_word;

    // Stage 1: capture register. Data only moves on an accepted read so the
    // output holds its last value through idle cycles.
    logic              r_s1_valid;
    logic [DATA_W-1:0] r_s1_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
        end else begin
            r_s1_valid <= w_usr_re;
            if (w_usr_re) begin
                r_s1_data <= w_rd_next;
            end
        end
    end

    if (RD_LAT == 2) begin : g_lat2
        logic              r_s2_valid;
        logic [DATA_W-1:0] r_s2_data;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_s2_valid <= 1'b0;
                r_s2_data  <= '0;
            end else begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_s2_data <= r_s1_data;
                end
            end
        end

        assign rd_data  = r_s2_data;
        assign rd_valid = r_s2_valid;
    end else begin : g_lat1
        assign rd_data  = r_s1_data;
        assign rd_valid = r_s1_valid;
    end

endmodule
